mkreq: RTL and testbench
========================

Name: mkreq

Overview:
- Request generator in front of one input port of the packet switch.
- Watches the flit stream `pkto` leaving the input buffer and decodes the destination from each head flit.
- Drives a one-hot request vector `reqi` to the switch arbiter, one bit per output port.
- Holds the request from the head flit until the tail flit has passed, so the whole packet keeps its output port.

Parameters:
- PKTW, 9: MSB index of a flit. Flit = 2-bit type in [PKTW:PKTW-1], 8-bit payload in [PKTW-2:0]. Comes from the `` `PKTW `` macro in sw.vh.
- PORT, 4: MSB index of the request vector, i.e. 5 output ports, numbered 0..4. Comes from the `` `PORT `` macro in sw.vh.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- pkto  input  PKTW+1 (10)  flit from input buffer; [9:8] = type, [7:0] = payload
- reqi  output  PORT+1 (5)  one-hot output-port request to the arbiter; all zero = no request

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Flit types in pkto[9:8]:
  - 00 = idle/empty
  - 10 = head; payload[7:0] = destination
  - 01 = body
  - 11 = tail
- Internal state: a registered request vector `req_q`. The output is driven directly from it: `reqi` = `req_q`.
- Reset: a clock edge with `rst`=1 sets `req_q` to 0, so `reqi` = 5'b00000. Reset wins over any flit present in the same cycle. Reset mid-packet drops the request; subsequent body/tail flits of that packet do not re-raise it.
- Destination decode: port = dest[2:0].
  - Valid destinations are 0..4, giving `onehot` = 1 << port.
  - dest[2:0] of 5..7 is an illegal port: `onehot` = 0, so no request is raised.
  - dest[7:3] is ignored.
- Latency: 1 cycle. A flit sampled at edge N affects `reqi` after edge N.
- Per-edge update, with rst=0:
  - head: `req_q` <= `onehot`(dest). This applies whether idle or already busy; a new head overrides a pending request.
  - body: `req_q` unchanged.
  - tail: `req_q` <= 0.
  - idle: `req_q` unchanged.
- A packet is requested from the cycle after its head through the cycle in which its tail is on `pkto`. `reqi` is 0 in the cycle after the tail.
- Body or tail with no preceding head: no request is raised (tail is a harmless clear).
- Back-to-back packets (tail in cycle N, head in cycle N+1): `reqi` is 0 for exactly one cycle, then the new request appears.
- At most one bit of `reqi` is ever set.
- X/Z on pkto[9:8] while `rst`=1 must not propagate to `reqi`.

Decomposition:
- Shared package `sw_pkg`, mirroring sw.vh:
  - PKTW and PORT constants.
  - Flit-type constants: FT_IDLE = 2'b00, FT_HEAD = 2'b10, FT_BODY = 2'b01, FT_TAIL = 2'b11.
  - Typedef `flit_t`: packed struct {type[1:0], data[7:0]}.
  - Typedef `req_t`: logic [PORT:0].
- One natural sub-module: `route_dec`, a combinational map from dest[7:0] to a one-hot `req_t`, including the illegal-port check. The same decoder is reused by the other input ports.
- `mkreq` itself holds only the type decode and `req_q`.

Test Plan:
- Reset: rst=1 for 2 edges with pkto=X, then idle 10'b00_00000000 -> `reqi`=00000 throughout.
- Single packet: head 10'b10_00000010, hold it 3 cycles, body 10'b01_00000000, body 10'b01_00000011, tail 10'b11_00000000, then idle.
  - Required: `reqi`=00100 from the edge after the first head through the tail cycle.
  - Required: `reqi`=00000 after the tail edge, and it stays 0 during the following 5 idle cycles.
- Port sweep: heads with dest 0, 1, 3, 4, each followed by a tail -> `reqi` = 00001, 00010, 01000, 10000 respectively, cleared after each tail.
- Illegal destination: head dest=8'h07 -> `reqi`=00000. Head dest=8'h0A -> `reqi`=00100, since only dest[2:0] is used.
- Head override and orphan flits:
  - Head dest=1, then head dest=3 -> `reqi` goes 00010 then 01000.
  - Body/tail with no head -> `reqi` stays 00000.
- Reset mid-packet: head dest=2, then rst=1 for one edge while a body flit is on `pkto` -> `reqi`=00000. It stays 00000 through the remaining body and tail flits.

Source files
------------

// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg: shared definitions for the packet switch input ports.
//   PKTW    - MSB index of a flit (flit is PKTW+1 bits wide)
//   PORT    - MSB index of the request vector (PORT+1 output ports)
//   FT_*    - flit type codes carried in the two MSBs of a flit
//   flit_t  - flit layout: {ftype[1:0], data[7:0]}
//   req_t   - one-hot output-port request vector
// -----------------------------------------------------------------------------
package sw_pkg;

  localparam int PKTW = 9;
  localparam int PORT = 4;

  localparam logic [1:0] FT_IDLE = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b10;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b11;

  // 'type' is a reserved word, so the type field is called ftype.
  typedef struct packed {
    logic [1:0] ftype;
    logic [7:0] data;
  } flit_t;

  typedef logic [PORT:0] req_t;

endpackage

// File: rtl/mkreq_route_dec.sv
// -----------------------------------------------------------------------------
// route_dec: combinational destination decoder shared by all input ports.
//   dest   in  8  destination byte from a head flit; only dest[2:0] is used
//   onehot out 5  one-hot request for the addressed output port; all zero
//                 when dest[2:0] names a port that does not exist (5..7)
// -----------------------------------------------------------------------------
module route_dec
  import sw_pkg::*;
(
  input  logic [7:0] dest,
  output req_t       onehot
);

  // Map the low three destination bits to a port; out-of-range ports request nothing.
  always_comb begin
    onehot = 5'b00000;
    case (dest[2:0])
      3'd0:    onehot = 5'b00001;
      3'd1:    onehot = 5'b00010;
      3'd2:    onehot = 5'b00100;
      3'd3:    onehot = 5'b01000;
      3'd4:    onehot = 5'b10000;
      default: onehot = 5'b00000;
    endcase
  end

endmodule

// File: rtl/mkreq.sv
// -----------------------------------------------------------------------------
// mkreq: request generator for one switch input port.
// Decodes the destination of each head flit leaving the input buffer and
// holds a one-hot request to the arbiter until the packet's tail has passed.
//   clk   in  1   system clock, rising edge
//   rst   in  1   synchronous active-high reset; clears the request
//   pkto  in  10  flit from the input buffer, [9:8] type, [7:0] payload
//   reqi  out 5   registered one-hot output-port request, zero = none
// -----------------------------------------------------------------------------
module mkreq
  import sw_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [PKTW:0] pkto,
  output logic [PORT:0] reqi
);

  flit_t flit_s;
  req_t  onehot_s;
  req_t  req_nxt_s;
  req_t  req_r;

  assign flit_s = flit_t'(pkto);

  route_dec u_route_dec (
    .dest   (flit_s.data),
    .onehot (onehot_s)
  );

  // Next request: a head (re)loads the decoded port, a tail releases it.
  always_comb begin
    req_nxt_s = req_r;
    case (flit_s.ftype)
      FT_HEAD: req_nxt_s = onehot_s;
      FT_TAIL: req_nxt_s = 5'b00000;
      FT_BODY: req_nxt_s = req_r;
      FT_IDLE: req_nxt_s = req_r;
      default: req_nxt_s = req_r;
    endcase
  end

  // Request register; reset is checked first so a flit (even X) cannot leak through.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r <= 5'b00000;
    end else begin
      req_r <= req_nxt_s;
    end
  end

  assign reqi = req_r;

endmodule

// File: tb/tb_mkreq.sv
// -----------------------------------------------------------------------------
// tb_mkreq: self-checking bench for mkreq. Each scenario task drives one
// flit per cycle, pushes the expected reqi after that edge onto a scoreboard
// queue, and pops/compares it once the edge has happened.
// -----------------------------------------------------------------------------
module tb_mkreq;

  logic       clk;
  logic       rst;
  logic [9:0] pkto;
  logic [4:0] reqi;

  logic [4:0] sb[$];
  int         vectors;
  int         errors;

  mkreq dut (
    .clk  (clk),
    .rst  (rst),
    .pkto (pkto),
    .reqi (reqi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and record what reqi must be after the edge.
  task automatic apply(input logic r, input logic [9:0] f, input logic [4:0] e);
    rst  = r;
    pkto = f;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    logic       rs [4];
    logic [9:0] fl [4];
    logic [4:0] ex [4];
    logic [4:0] exp_v;
    rs = '{1'b1, 1'b1, 1'b0, 1'b0};
    fl = '{10'bxx_xxxxxxxx, 10'bxx_xxxxxxxx, 10'b00_00000000, 10'b00_00000000};
    ex = '{5'b00000, 5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      apply(rs[i], fl[i], ex[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (reqi !== exp_v) begin
        errors++;
        $display("FAIL reset[%0d] reqi=%b expected=%b", i, reqi, exp_v);
      end
    end
  endtask

  task automatic test_single_packet();
    logic [9:0] fl [11];
    logic [4:0] ex [11];
    logic [4:0] exp_v;
    fl = '{10'b10_00000010, 10'b10_00000010, 10'b10_00000010, 10'b01_00000000,
           10'b01_00000011, 10'b11_00000000, 10'b00_00000000, 10'b00_00000000,
           10'b00_00000000, 10'b00_00000000, 10'b00_00000000};
    ex = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000,
           5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 11; i++) begin
      apply(1'b0, fl[i], ex[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (reqi !== exp_v) begin
        errors++;
        $display("FAIL single[%0d] reqi=%b expected=%b", i, reqi, exp_v);
      end
    end
  endtask

  task automatic test_port_sweep();
    logic [9:0] fl [8];
    logic [4:0] ex [8];
    logic [4:0] exp_v;
    fl = '{10'b10_00000000, 10'b11_00000000, 10'b10_00000001, 10'b11_00000000,
           10'b10_00000011, 10'b11_00000000, 10'b10_00000100, 10'b11_00000000};
    ex = '{5'b00001, 5'b00000, 5'b00010, 5'b00000,
           5'b01000, 5'b00000, 5'b10000, 5'b00000};
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, fl[i], ex[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (reqi !== exp_v) begin
        errors++;
        $display("FAIL sweep[%0d] reqi=%b expected=%b", i, reqi, exp_v);
      end
    end
  endtask

  task automatic test_illegal_dest();
    logic [9:0] fl [9];
    logic [4:0] ex [9];
    logic [4:0] exp_v;
    // 07 and FD/FE (ports 7, 5, 6) are illegal; 0A aliases to port 2;
    // an illegal head over a live request clears it.
    fl = '{10'b10_00000111, 10'b11_00000000, 10'b10_00001010, 10'b11_00000000,
           10'b10_11111101, 10'b10_11111110, 10'b10_00000001, 10'b10_00000111,
           10'b11_00000000};
    ex = '{5'b00000, 5'b00000, 5'b00100, 5'b00000,
           5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000};
    for (int i = 0; i < 9; i++) begin
      apply(1'b0, fl[i], ex[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (reqi !== exp_v) begin
        errors++;
        $display("FAIL illegal[%0d] reqi=%b expected=%b", i, reqi, exp_v);
      end
    end
  endtask

  task automatic test_override_orphan();
    logic [9:0] fl [7];
    logic [4:0] ex [7];
    logic [4:0] exp_v;
    fl = '{10'b10_00000001, 10'b10_00000011, 10'b11_00000000, 10'b01_00000100,
           10'b11_00000010, 10'b00_00000000, 10'b01_00000000};
    ex = '{5'b00010, 5'b01000, 5'b00000, 5'b00000,
           5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, fl[i], ex[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (reqi !== exp_v) begin
        errors++;
        $display("FAIL override[%0d] reqi=%b expected=%b", i, reqi, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] fl [6];
    logic [4:0] ex [6];
    logic [4:0] exp_v;
    fl = '{10'b10_00000001, 10'b01_00000000, 10'b11_00000000,
           10'b10_00000100, 10'b01_00000000, 10'b11_00000000};
    ex = '{5'b00010, 5'b00010, 5'b00000, 5'b10000, 5'b10000, 5'b00000};
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, fl[i], ex[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (reqi !== exp_v) begin
        errors++;
        $display("FAIL b2b[%0d] reqi=%b expected=%b", i, reqi, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic       rs [8];
    logic [9:0] fl [8];
    logic [4:0] ex [8];
    logic [4:0] exp_v;
    // Last three vectors: a head under reset must be ignored.
    rs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fl = '{10'b10_00000010, 10'b01_00000000, 10'b01_00000000, 10'b01_00000000,
           10'b11_00000000, 10'b10_00000011, 10'b10_00000001, 10'b00_00000000};
    ex = '{5'b00100, 5'b00000, 5'b00000, 5'b00000,
           5'b00000, 5'b01000, 5'b00000, 5'b00000};
    for (int i = 0; i < 8; i++) begin
      apply(rs[i], fl[i], ex[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      vectors++;
      if (reqi !== exp_v) begin
        errors++;
        $display("FAIL rstmid[%0d] reqi=%b expected=%b", i, reqi, exp_v);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    pkto    = 10'b00_00000000;
    @(posedge clk); #1;
    test_reset();
    test_single_packet();
    test_port_sweep();
    test_illegal_dest();
    test_override_orphan();
    test_back_to_back();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
